ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage_if.sv | 64 ++++++
 rtl/ex_mem_stage.sv | 125 ++++++++++++
 tb/tb_ex_mem_stage.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if
// Bundles everything the EX stage exchanges with the rest of the pipeline,
// apart from clock and reset:
//   - ID/EX operands, register specifiers, immediates and control
//   - MEM/WB writeback destination, enable and value (forwarding source)
//   - stall / flush hazard controls
//   - registered EX/MEM results and control
// Modports:
//   master : pipeline-side view (drives ID/EX, MEM/WB, hazard inputs)
//   slave  : the EX stage itself (consumes inputs, drives EX/MEM outputs)
interface ex_mem_stage_if;
    logic [31:0] Readdata1_ID_EX;
    logic [31:0] Readdata2_ID_EX;
    logic [31:0] ID_EX_lui;
    logic [31:0] ID_EX_immediateaddress;
    logic [4:0]  ID_EXrs;
    logic [4:0]  ID_EXrt;
    logic [4:0]  ID_EXrd;
    logic        ALUsrc_ID_EX;
    logic        RegDst_ID_EX;
    logic        MemRead_ID_EX;
    logic        MemWrite_ID_EX;
    logic        MemtoReg_ID_EX;
    logic        RegWrite_ID_EX;
    logic        immediate_ID_EX;
    logic [1:0]  Aluop_ID_EX;
    logic [4:0]  MEM_WBrd;
    logic        RegWrite_MEM_WB;
    logic [31:0] Writedata_MEM_WB;
    logic        stall;
    logic        flush;
    logic [31:0] ALUresult_EX_MEM;
    logic [31:0] Writedata_EX_MEM;
    logic [4:0]  EX_MEMrd;
    logic        MemRead_EX_MEM;
    logic        MemWrite_EX_MEM;
    logic        MemtoReg_EX_MEM;
    logic        RegWrite_EX_MEM;
    logic        Zero_EX_MEM;

    modport master (
        output Readdata1_ID_EX, Readdata2_ID_EX, ID_EX_lui, ID_EX_immediateaddress,
        output ID_EXrs, ID_EXrt, ID_EXrd,
        output ALUsrc_ID_EX, RegDst_ID_EX, MemRead_ID_EX, MemWrite_ID_EX,
        output MemtoReg_ID_EX, RegWrite_ID_EX, immediate_ID_EX, Aluop_ID_EX,
        output MEM_WBrd, RegWrite_MEM_WB, Writedata_MEM_WB,
        output stall, flush,
        input  ALUresult_EX_MEM, Writedata_EX_MEM, EX_MEMrd,
        input  MemRead_EX_MEM, MemWrite_EX_MEM, MemtoReg_EX_MEM,
        input  RegWrite_EX_MEM, Zero_EX_MEM
    );

    modport slave (
        input  Readdata1_ID_EX, Readdata2_ID_EX, ID_EX_lui, ID_EX_immediateaddress,
        input  ID_EXrs, ID_EXrt, ID_EXrd,
        input  ALUsrc_ID_EX, RegDst_ID_EX, MemRead_ID_EX, MemWrite_ID_EX,
        input  MemtoReg_ID_EX, RegWrite_ID_EX, immediate_ID_EX, Aluop_ID_EX,
        input  MEM_WBrd, RegWrite_MEM_WB, Writedata_MEM_WB,
        input  stall, flush,
        output ALUresult_EX_MEM, Writedata_EX_MEM, EX_MEMrd,
        output MemRead_EX_MEM, MemWrite_EX_MEM, MemtoReg_EX_MEM,
        output RegWrite_EX_MEM, Zero_EX_MEM
    );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
// Execute stage of a 5-stage MIPS-style pipeline together with the EX/MEM
// pipeline register. Operands are forwarded from EX/MEM (highest priority)
// or MEM/WB, the ALU evaluates the operation, and the result, store data,
// destination and memory/writeback control are registered for MEM.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset, clears every output
//   bus  : ex_mem_stage_if.slave -- ID/EX inputs, MEM/WB forwarding source,
//          stall/flush, and the registered EX/MEM outputs
module ex_mem_stage (
    input  logic          clk,
    input  logic          rst,
    ex_mem_stage_if.slave bus
);

    logic [31:0] alu_result_q;
    logic [31:0] store_data_q;
    logic [4:0]  dest_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic        mem_to_reg_q;
    logic        reg_write_q;
    logic        zero_q;

    logic [31:0] operand_a;
    logic [31:0] forwarded_b;
    logic [31:0] operand_b;
    logic [31:0] alu_result;
    logic [4:0]  dest;
    logic [4:0]  shamt;
    logic [5:0]  funct;

    assign shamt = bus.ID_EX_immediateaddress[10:6];
    assign funct = bus.ID_EX_immediateaddress[5:0];

    // Forwarding reads the live EX/MEM register contents, so a producer that
    // is held by a stall keeps feeding its result to the waiting consumer.
    // Register 0 is hard-wired to zero and must never be forwarded.
    always_comb begin
        operand_a = bus.Readdata1_ID_EX;
        if (reg_write_q && (dest_q != 5'd0) && (dest_q == bus.ID_EXrs)) begin
            operand_a = alu_result_q;
        end else if (bus.RegWrite_MEM_WB && (bus.MEM_WBrd != 5'd0) &&
                     (bus.MEM_WBrd == bus.ID_EXrs)) begin
            operand_a = bus.Writedata_MEM_WB;
        end

        forwarded_b = bus.Readdata2_ID_EX;
        if (reg_write_q && (dest_q != 5'd0) && (dest_q == bus.ID_EXrt)) begin
            forwarded_b = alu_result_q;
        end else if (bus.RegWrite_MEM_WB && (bus.MEM_WBrd != 5'd0) &&
                     (bus.MEM_WBrd == bus.ID_EXrt)) begin
            forwarded_b = bus.Writedata_MEM_WB;
        end
    end

    // The forwarded B always goes out as store data; the ALU sees either it
    // or the sign-extended immediate.
    assign operand_b = bus.ALUsrc_ID_EX ? bus.ID_EX_immediateaddress : forwarded_b;

    // ALU. Aluop 10 decodes the R-type funct field; shifts act on B by the
    // shamt field. The LUI path overrides whatever the ALU computed.
    // Arithmetic simply wraps at 32 bits.
    always_comb begin
        alu_result = 32'd0;
        case (bus.Aluop_ID_EX)
            2'b00: alu_result = operand_a + operand_b;
            2'b01: alu_result = operand_a - operand_b;
            2'b11: alu_result = operand_a | {16'd0, bus.ID_EX_immediateaddress[15:0]};
            2'b10: begin
                case (funct)
                    6'h20:   alu_result = operand_a + operand_b;
                    6'h22:   alu_result = operand_a - operand_b;
                    6'h24:   alu_result = operand_a & operand_b;
                    6'h25:   alu_result = operand_a | operand_b;
                    6'h2A:   alu_result = {31'd0, ($signed(operand_a) < $signed(operand_b))};
                    6'h00:   alu_result = operand_b << shamt;
                    6'h02:   alu_result = operand_b >> shamt;
                    default: alu_result = 32'd0;
                endcase
            end
            default: alu_result = 32'd0;
        endcase
        if (bus.immediate_ID_EX) begin
            alu_result = bus.ID_EX_lui;
        end
    end

    assign dest = bus.RegDst_ID_EX ? bus.ID_EXrd : bus.ID_EXrt;

    // EX/MEM pipeline register. Reset beats flush, flush beats stall; a
    // flushed slot is a full bubble, data fields included.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            alu_result_q <= 32'd0;
            store_data_q <= 32'd0;
            dest_q       <= 5'd0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            zero_q       <= 1'b0;
        end else if (!bus.stall) begin
            alu_result_q <= alu_result;
            store_data_q <= forwarded_b;
            dest_q       <= dest;
            mem_read_q   <= bus.MemRead_ID_EX;
            mem_write_q  <= bus.MemWrite_ID_EX;
            mem_to_reg_q <= bus.MemtoReg_ID_EX;
            reg_write_q  <= bus.RegWrite_ID_EX;
            zero_q       <= (alu_result == 32'd0);
        end
    end

    assign bus.ALUresult_EX_MEM = alu_result_q;
    assign bus.Writedata_EX_MEM = store_data_q;
    assign bus.EX_MEMrd         = dest_q;
    assign bus.MemRead_EX_MEM   = mem_read_q;
    assign bus.MemWrite_EX_MEM  = mem_write_q;
    assign bus.MemtoReg_EX_MEM  = mem_to_reg_q;
    assign bus.RegWrite_EX_MEM  = reg_write_q;
    assign bus.Zero_EX_MEM      = zero_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage
// Directed test of ex_mem_stage: reset, ALU operations, forwarding priority,
// $zero guard, stall/flush behaviour and reset in mid-stream. Expected values
// are hand-computed constants.
module tb_ex_mem_stage;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    ex_mem_stage_if bus ();

    ex_mem_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive an idle ID/EX slot and idle MEM/WB stage.
    task automatic clear_instr();
        bus.Readdata1_ID_EX        = 32'd0;
        bus.Readdata2_ID_EX        = 32'd0;
        bus.ID_EX_lui              = 32'd0;
        bus.ID_EX_immediateaddress = 32'd0;
        bus.ID_EXrs                = 5'd0;
        bus.ID_EXrt                = 5'd0;
        bus.ID_EXrd                = 5'd0;
        bus.ALUsrc_ID_EX           = 1'b0;
        bus.RegDst_ID_EX           = 1'b0;
        bus.MemRead_ID_EX          = 1'b0;
        bus.MemWrite_ID_EX         = 1'b0;
        bus.MemtoReg_ID_EX         = 1'b0;
        bus.RegWrite_ID_EX         = 1'b0;
        bus.immediate_ID_EX        = 1'b0;
        bus.Aluop_ID_EX            = 2'b00;
        bus.MEM_WBrd               = 5'd0;
        bus.RegWrite_MEM_WB        = 1'b0;
        bus.Writedata_MEM_WB       = 32'd0;
    endtask

    function automatic logic [73:0] all_outs();
        return {bus.ALUresult_EX_MEM, bus.Writedata_EX_MEM, bus.EX_MEMrd,
                bus.MemRead_EX_MEM, bus.MemWrite_EX_MEM, bus.MemtoReg_EX_MEM,
                bus.RegWrite_EX_MEM, bus.Zero_EX_MEM};
    endfunction

    // Reset wins over stall and flush, and an instruction presented during
    // reset is dropped.
    task automatic test_reset();
        clear_instr();
        rst = 1'b1;
        bus.stall = 1'b1;
        bus.flush = 1'b0;
        bus.Readdata1_ID_EX = 32'd5;
        bus.ID_EXrd = 5'd3;
        bus.RegDst_ID_EX = 1'b1;
        bus.RegWrite_ID_EX = 1'b1;
        bus.MemRead_ID_EX = 1'b1;
        tick();
        compared++;
        if (all_outs() !== 74'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", all_outs());
        end
        bus.stall = 1'b0;
        bus.Readdata1_ID_EX = 32'd9;
        bus.MemWrite_ID_EX = 1'b1;
        tick();
        compared++;
        if (all_outs() !== 74'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_discard: got %h expected 0", all_outs());
        end
    endtask

    // First edge after reset captures a plain register add.
    task automatic test_add();
        clear_instr();
        rst = 1'b0;
        bus.ID_EXrs = 5'd1;  bus.Readdata1_ID_EX = 32'd5;
        bus.ID_EXrt = 5'd2;  bus.Readdata2_ID_EX = 32'd7;
        bus.Aluop_ID_EX = 2'b10;
        bus.ID_EX_immediateaddress = 32'h20;
        bus.RegDst_ID_EX = 1'b1; bus.ID_EXrd = 5'd3;
        bus.RegWrite_ID_EX = 1'b1;
        tick();
        compared++;
        if (bus.ALUresult_EX_MEM !== 32'd12) begin
            mismatched++;
            $display("[TB] FAIL add_result: got %h expected %h", bus.ALUresult_EX_MEM, 32'd12);
        end
        compared++;
        if (bus.EX_MEMrd !== 5'd3) begin
            mismatched++;
            $display("[TB] FAIL add_rd: got %0d expected 3", bus.EX_MEMrd);
        end
        compared++;
        if (bus.Zero_EX_MEM !== 1'b0 || bus.RegWrite_EX_MEM !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL add_flags: got zero=%b regwrite=%b expected zero=0 regwrite=1",
                     bus.Zero_EX_MEM, bus.RegWrite_EX_MEM);
        end
        compared++;
        if (bus.Writedata_EX_MEM !== 32'd7) begin
            mismatched++;
            $display("[TB] FAIL add_storedata: got %h expected 7", bus.Writedata_EX_MEM);
        end
    endtask

    // EX/MEM beats MEM/WB, MEM/WB used when EX/MEM does not match, and the
    // store data path is forwarded too.
    task automatic test_back_to_back();
        clear_instr();
        bus.ID_EXrs = 5'd3; bus.Readdata1_ID_EX = 32'd1000;
        bus.ID_EXrt = 5'd4; bus.Readdata2_ID_EX = 32'd1;
        bus.Aluop_ID_EX = 2'b10; bus.ID_EX_immediateaddress = 32'h20;
        bus.RegDst_ID_EX = 1'b1; bus.ID_EXrd = 5'd3; bus.RegWrite_ID_EX = 1'b1;
        bus.MEM_WBrd = 5'd3; bus.RegWrite_MEM_WB = 1'b1; bus.Writedata_MEM_WB = 32'd99;
        tick();
        compared++;
        if (bus.ALUresult_EX_MEM !== 32'd13) begin
            mismatched++;
            $display("[TB] FAIL fwd_exmem_priority: got %0d expected 13", bus.ALUresult_EX_MEM);
        end

        bus.ID_EXrs = 5'd5; bus.Readdata1_ID_EX = 32'd0;
        bus.ID_EXrt = 5'd6; bus.Readdata2_ID_EX = 32'd1;
        bus.ID_EXrd = 5'd7;
        bus.MEM_WBrd = 5'd5;
        tick();
        compared++;
        if (bus.ALUresult_EX_MEM !== 32'd100) begin
            mismatched++;
            $display("[TB] FAIL fwd_memwb: got %0d expected 100", bus.ALUresult_EX_MEM);
        end

        clear_instr();
        bus.ID_EXrs = 5'd0; bus.Readdata1_ID_EX = 32'd8;
        bus.ID_EXrt = 5'd7; bus.Readdata2_ID_EX = 32'd0;
        bus.ALUsrc_ID_EX = 1'b1; bus.ID_EX_immediateaddress = 32'd4;
        bus.MemWrite_ID_EX = 1'b1;
        tick();
        compared++;
        if (bus.ALUresult_EX_MEM !== 32'd12) begin
            mismatched++;
            $display("[TB] FAIL store_addr: got %0d expected 12", bus.ALUresult_EX_MEM);
        end
        compared++;
        if (bus.Writedata_EX_MEM !== 32'd100 || bus.MemWrite_EX_MEM !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL fwd_storedata: got %0d memwrite=%b expected 100 memwrite=1",
                     bus.Writedata_EX_MEM, bus.MemWrite_EX_MEM);
        end
    endtask

    // A write to register 0 must not be forwarded from either stage.
    task automatic test_zero_guard();
        clear_instr();
        bus.ID_EXrs = 5'd1; bus.Readdata1_ID_EX = 32'd5;
        bus.ALUsrc_ID_EX = 1'b1; bus.ID_EX_immediateaddress = 32'd3;
        bus.ID_EXrt = 5'd0; bus.RegWrite_ID_EX = 1'b1;
        tick();
        compared++;
        if (bus.ALUresult_EX_MEM !== 32'd8 || bus.EX_MEMrd !== 5'd0) begin
            mismatched++;
            $display("[TB] FAIL zero_producer: got %0d rd=%0d expected 8 rd=0",
                     bus.ALUresult_EX_MEM, bus.EX_MEMrd);
        end
        clear_instr();
        bus.MEM_WBrd = 5'd0; bus.RegWrite_MEM_WB = 1'b1; bus.Writedata_MEM_WB = 32'd55;
        tick();
        compared++;
        if (bus.ALUresult_EX_MEM !== 32'd0 || bus.Zero_EX_MEM !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL zero_guard: got %0d zero=%b expected 0 zero=1",
                     bus.ALUresult_EX_MEM, bus.Zero_EX_MEM);
        end
    endtask

    typedef struct {
        logic [1:0]  aluop;
        logic        alusrc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] expected;
    } alu_vec_t;

    // ALU operation table, including wrap-around, signed compare and shifts.
    task automatic test_alu_ops();
        alu_vec_t vecs[13];
        vecs[0]  = '{2'b01, 1'b0, 32'h80000000, 32'h80000000, 32'h0,        32'h0};
        vecs[1]  = '{2'b00, 1'b1, 32'h7FFFFFFF, 32'h0,        32'h1,        32'h80000000};
        vecs[2]  = '{2'b10, 1'b0, 32'hFFFFFFF0, 32'h13,       32'h20,       32'h3};
        vecs[3]  = '{2'b10, 1'b0, 32'hFFFFFFF0, 32'h13,       32'h22,       32'hFFFFFFDD};
        vecs[4]  = '{2'b10, 1'b0, 32'hFFFFFFF0, 32'h13,       32'h24,       32'h10};
        vecs[5]  = '{2'b10, 1'b0, 32'hFFFFFFF0, 32'h13,       32'h25,       32'hFFFFFFF3};
        vecs[6]  = '{2'b10, 1'b0, 32'hFFFFFFF0, 32'h13,       32'h2A,       32'h1};
        vecs[7]  = '{2'b10, 1'b0, 32'h80000000, 32'h1,        32'h2A,       32'h1};
        vecs[8]  = '{2'b10, 1'b0, 32'h1,        32'h80000000, 32'h2A,       32'h0};
        vecs[9]  = '{2'b10, 1'b0, 32'hFFFFFFF0, 32'h13,       32'h100,      32'h130};
        vecs[10] = '{2'b10, 1'b0, 32'hFFFFFFF0, 32'h13,       32'h82,       32'h4};
        vecs[11] = '{2'b10, 1'b0, 32'hFFFFFFF0, 32'h13,       32'h3F,       32'h0};
        vecs[12] = '{2'b11, 1'b1, 32'h12340000, 32'h0,        32'hFFFF8001, 32'h12348001};
        clear_instr();
        bus.ID_EXrs = 5'd9; bus.ID_EXrt = 5'd10; bus.ID_EXrd = 5'd11;
        bus.RegDst_ID_EX = 1'b1;
        for (int i = 0; i < 13; i++) begin
            bus.Aluop_ID_EX = vecs[i].aluop;
            bus.ALUsrc_ID_EX = vecs[i].alusrc;
            bus.Readdata1_ID_EX = vecs[i].a;
            bus.Readdata2_ID_EX = vecs[i].b;
            bus.ID_EX_immediateaddress = vecs[i].imm;
            tick();
            compared++;
            if (bus.ALUresult_EX_MEM !== vecs[i].expected ||
                bus.Zero_EX_MEM !== (vecs[i].expected == 32'd0)) begin
                mismatched++;
                $display("[TB] FAIL alu_vec%0d: got %h zero=%b expected %h zero=%b", i,
                         bus.ALUresult_EX_MEM, bus.Zero_EX_MEM, vecs[i].expected,
                         (vecs[i].expected == 32'd0));
            end
        end
        bus.immediate_ID_EX = 1'b1;
        bus.ID_EX_lui = 32'hABCD0000;
        bus.Aluop_ID_EX = 2'b10;
        bus.ID_EX_immediateaddress = 32'h22;
        bus.RegDst_ID_EX = 1'b0;
        tick();
        compared++;
        if (bus.ALUresult_EX_MEM !== 32'hABCD0000 || bus.EX_MEMrd !== 5'd10) begin
            mismatched++;
            $display("[TB] FAIL lui_rt_dest: got %h rd=%0d expected abcd0000 rd=10",
                     bus.ALUresult_EX_MEM, bus.EX_MEMrd);
        end
    endtask

    // Stall holds everything, a held producer still forwards, and flush
    // overrides stall with a bubble.
    task automatic test_stall_flush();
        clear_instr();
        bus.ID_EXrs = 5'd1; bus.Readdata1_ID_EX = 32'd10;
        bus.ID_EXrt = 5'd2; bus.Readdata2_ID_EX = 32'd5;
        bus.RegDst_ID_EX = 1'b1; bus.ID_EXrd = 5'd4;
        bus.RegWrite_ID_EX = 1'b1; bus.MemWrite_ID_EX = 1'b1;
        tick();
        compared++;
        if (bus.ALUresult_EX_MEM !== 32'd15) begin
            mismatched++;
            $display("[TB] FAIL stall_producer: got %0d expected 15", bus.ALUresult_EX_MEM);
        end
        clear_instr();
        bus.stall = 1'b1;
        bus.ID_EXrs = 5'd4; bus.Readdata1_ID_EX = 32'd0;
        bus.RegDst_ID_EX = 1'b1; bus.ID_EXrd = 5'd6;
        for (int i = 0; i < 2; i++) begin
            tick();
            compared++;
            if (bus.ALUresult_EX_MEM !== 32'd15 || bus.EX_MEMrd !== 5'd4 ||
                bus.RegWrite_EX_MEM !== 1'b1 || bus.MemWrite_EX_MEM !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL stall_hold%0d: got %0d rd=%0d rw=%b mw=%b expected 15 rd=4 rw=1 mw=1",
                         i, bus.ALUresult_EX_MEM, bus.EX_MEMrd, bus.RegWrite_EX_MEM,
                         bus.MemWrite_EX_MEM);
            end
        end
        bus.stall = 1'b0;
        tick();
        compared++;
        if (bus.ALUresult_EX_MEM !== 32'd15 || bus.EX_MEMrd !== 5'd6) begin
            mismatched++;
            $display("[TB] FAIL stall_forward: got %0d rd=%0d expected 15 rd=6",
                     bus.ALUresult_EX_MEM, bus.EX_MEMrd);
        end
        bus.RegWrite_ID_EX = 1'b1; bus.MemWrite_ID_EX = 1'b1;
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        tick();
        compared++;
        if (all_outs() !== 74'd0) begin
            mismatched++;
            $display("[TB] FAIL flush_over_stall: got %h expected 0", all_outs());
        end
        bus.stall = 1'b0;
        bus.flush = 1'b0;
    endtask

    // Reset with a load in flight clears outputs and leaves nothing to forward.
    task automatic test_reset_midstream();
        clear_instr();
        bus.ID_EXrs = 5'd1; bus.Readdata1_ID_EX = 32'd20;
        bus.ALUsrc_ID_EX = 1'b1; bus.ID_EXrt = 5'd5;
        bus.MemRead_ID_EX = 1'b1; bus.MemtoReg_ID_EX = 1'b1; bus.RegWrite_ID_EX = 1'b1;
        tick();
        compared++;
        if (bus.ALUresult_EX_MEM !== 32'd20 || bus.MemRead_EX_MEM !== 1'b1 ||
            bus.MemtoReg_EX_MEM !== 1'b1 || bus.EX_MEMrd !== 5'd5) begin
            mismatched++;
            $display("[TB] FAIL load_capture: got %0d mr=%b m2r=%b rd=%0d expected 20 mr=1 m2r=1 rd=5",
                     bus.ALUresult_EX_MEM, bus.MemRead_EX_MEM, bus.MemtoReg_EX_MEM, bus.EX_MEMrd);
        end
        bus.Readdata1_ID_EX = 32'd40;
        rst = 1'b1;
        tick();
        compared++;
        if (all_outs() !== 74'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_midstream: got %h expected 0", all_outs());
        end
        rst = 1'b0;
        clear_instr();
        bus.ID_EXrs = 5'd5; bus.Readdata1_ID_EX = 32'd1;
        tick();
        compared++;
        if (bus.ALUresult_EX_MEM !== 32'd1) begin
            mismatched++;
            $display("[TB] FAIL no_stale_forward: got %0d expected 1", bus.ALUresult_EX_MEM);
        end
    endtask

    // Run every scenario in order and report.
    initial begin
        compared = 0;
        mismatched = 0;
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        clear_instr();
        test_reset();
        test_add();
        test_back_to_back();
        test_zero_guard();
        test_alu_ops();
        test_stall_flush();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
